// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- generic inter-stage pipeline register for the five-stage core.
//
// One instruction slot (PC, instruction word, opaque payload) with a
// valid/ready handshake. A flush discards every held and incoming entry and
// leaves a bubble that carries flush_pc. A drained slot leaves a bubble that
// keeps the last PC. Whenever out_valid is 0, out_instr and out_data read 0.
//
// Optional feature macro: PIPE_STAGE_SKID_EN
//   defined   : main register plus one skid entry; in_ready is a flop output
//               with no combinational path from out_ready; occupancy 0..2.
//   undefined : main register only; in_ready = !out_valid | out_ready;
//               occupancy 0..1.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   in_pc/in_instr      incoming instruction PC and word
//   in_data             incoming payload (DATA_W bits)
//   flush/flush_pc      discard all entries, bubble takes flush_pc
//   out_valid/out_ready downstream handshake
//   out_pc/out_instr    outgoing PC (or bubble PC) and word (0 when invalid)
//   out_data            outgoing payload (0 when invalid)
//   occupancy           number of valid entries held
module pipe_stage_reg #(
   parameter int          DATA_W   = 96,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_pc,
   input  logic [31:0]       in_instr,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   input  logic [31:0]       flush_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_instr,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic              m_vld_p1;
   logic [31:0]       m_pc_p1;
   logic [31:0]       m_instr_p1;
   logic [DATA_W-1:0] m_data_p1;

   logic              in_xfer;
   logic              out_xfer;
   logic              m_load;
   logic [31:0]       m_pc_nxt;
   logic [31:0]       m_instr_nxt;
   logic [DATA_W-1:0] m_data_nxt;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = m_vld_p1 & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_vld_p0;
   logic [31:0]       skid_pc_p0;
   logic [31:0]       skid_instr_p0;
   logic [DATA_W-1:0] skid_data_p0;
   logic              skid_load;

   // Ready depends only on the skid flop, so out_ready never reaches in_ready.
   assign in_ready = ~skid_vld_p0;

   always_comb begin
      m_load      = 1'b0;
      skid_load   = 1'b0;
      m_pc_nxt    = in_pc;
      m_instr_nxt = in_instr;
      m_data_nxt  = in_data;
      if (out_xfer && skid_vld_p0) begin
         // in_ready is low while the skid is full, so no input competes here.
         m_load      = 1'b1;
         m_pc_nxt    = skid_pc_p0;
         m_instr_nxt = skid_instr_p0;
         m_data_nxt  = skid_data_p0;
      end else if (in_xfer && (!m_vld_p1 || out_xfer)) begin
         m_load = 1'b1;
      end else if (in_xfer) begin
         skid_load = 1'b1;
      end
   end

   // ---- skid stage ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skid_vld_p0 <= 1'b0;
      end else if (flush) begin
         skid_vld_p0 <= 1'b0;
      end else if (skid_load) begin
         skid_vld_p0 <= 1'b1;
      end else if (out_xfer) begin
         skid_vld_p0 <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (skid_load) begin
         skid_pc_p0    <= in_pc;
         skid_instr_p0 <= in_instr;
         skid_data_p0  <= in_data;
      end
   end

   assign occupancy = {1'b0, m_vld_p1} + {1'b0, skid_vld_p0};
`else
   assign in_ready    = ~m_vld_p1 | out_ready;
   assign m_load      = in_xfer;
   assign m_pc_nxt    = in_pc;
   assign m_instr_nxt = in_instr;
   assign m_data_nxt  = in_data;
   assign occupancy   = {1'b0, m_vld_p1};
`endif

   // ---- main stage ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_vld_p1 <= 1'b0;
         m_pc_p1  <= RESET_PC;
      end else if (flush) begin
         m_vld_p1 <= 1'b0;
         m_pc_p1  <= flush_pc;
      end else if (m_load) begin
         m_vld_p1 <= 1'b1;
         m_pc_p1  <= m_pc_nxt;
      end else if (out_xfer) begin
         // Drained with no refill: the bubble keeps the drained PC.
         m_vld_p1 <= 1'b0;
      end
   end

   // Word and payload need no reset: they are masked to 0 while invalid.
   always_ff @(posedge clk) begin
      if (m_load && !flush) begin
         m_instr_p1 <= m_instr_nxt;
         m_data_p1  <= m_data_nxt;
      end
   end

   assign out_valid = m_vld_p1;
   assign out_pc    = m_pc_p1;
   assign out_instr = m_vld_p1 ? m_instr_p1 : 32'd0;
   assign out_data  = m_vld_p1 ? m_data_p1 : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: table of per-cycle vectors plus hand-written
// sequences for reset, asynchronous reset while full and (skid build) the
// back-pressure / flush-while-full corner cases.
module tb_pipe_stage_reg;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_pc;
   logic [31:0]   in_instr;
   logic [DW-1:0] in_data;
   logic          flush;
   logic [31:0]   flush_pc;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_pc;
   logic [31:0]   out_instr;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;

   int total = 0;
   int bad   = 0;

   pipe_stage_reg #(.DATA_W(DW), .RESET_PC(32'h0000_3000)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_pc    (in_pc),
      .in_instr (in_instr),
      .in_data  (in_data),
      .flush    (flush),
      .flush_pc (flush_pc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_pc   (out_pc),
      .out_instr(out_instr),
      .out_data (out_data),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          iv;
      logic [31:0]   ipc;
      logic [31:0]   iins;
      logic [DW-1:0] idat;
      logic          fl;
      logic [31:0]   fpc;
      logic          ordy;
      logic          xrdy;   // in_ready expected before the edge
      logic          xov;    // outputs expected after the edge
      logic [31:0]   xpc;
      logic [31:0]   xins;
      logic [DW-1:0] xdat;
      logic [1:0]    xocc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic iv, logic [31:0] ipc, logic [31:0] iins,
                               logic [DW-1:0] idat, logic fl, logic [31:0] fpc,
                               logic ordy, logic xrdy, logic xov, logic [31:0] xpc,
                               logic [31:0] xins, logic [DW-1:0] xdat, logic [1:0] xocc);
      vec_t v;
      v.iv = iv; v.ipc = ipc; v.iins = iins; v.idat = idat;
      v.fl = fl; v.fpc = fpc; v.ordy = ordy;
      v.xrdy = xrdy; v.xov = xov; v.xpc = xpc; v.xins = xins;
      v.xdat = xdat; v.xocc = xocc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [31:0] ipc, input logic [31:0] iins,
                        input logic [DW-1:0] idat, input logic fl, input logic [31:0] fpc,
                        input logic ordy);
      in_valid = iv; in_pc = ipc; in_instr = iins; in_data = idat;
      flush = fl; flush_pc = fpc; out_ready = ordy;
   endtask

   task automatic chk_out(input string tag, input logic xov, input logic [31:0] xpc,
                          input logic [31:0] xins, input logic [DW-1:0] xdat,
                          input logic [1:0] xocc);
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(xov));
      chk({tag, ".out_pc"},    64'(out_pc),    64'(xpc));
      chk({tag, ".out_instr"}, 64'(out_instr), 64'(xins));
      chk({tag, ".out_data"},  64'(out_data),  64'(xdat));
      chk({tag, ".occupancy"}, 64'(occupancy), 64'(xocc));
   endtask

   // One cycle: drive at negedge, check in_ready, clock, check registered outputs.
   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      drive(v.iv, v.ipc, v.iins, v.idat, v.fl, v.fpc, v.ordy);
      #1;
      chk({tag, ".in_ready"}, 64'(in_ready), 64'(v.xrdy));
      @(posedge clk);
      #1;
      chk_out(tag, v.xov, v.xpc, v.xins, v.xdat, v.xocc);
   endtask

   initial begin
      logic [31:0] pc;
      logic [31:0] ins;
      logic [DW-1:0] dat;

      // ---- vector table ----
      for (int k = 0; k < 8; k++) begin
         pc  = 32'h0000_3000 + 32'(4 * k);
         ins = (k == 0) ? 32'h3C01_1234 : 32'h2421_0000 + 32'(k);
         dat = 16'h0100 + 16'(k);
         tbl.push_back(mk(1, pc, ins, dat, 0, 0, 1, 1, 1, pc, ins, dat, 2'd1));
      end
`ifdef PIPE_STAGE_SKID_EN
      tbl.push_back(mk(1, 32'h3020, 32'h2421_0008, 16'h0108, 0, 0, 0,
                       1, 1, 32'h301C, 32'h2421_0007, 16'h0107, 2'd2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,
                       0, 1, 32'h3020, 32'h2421_0008, 16'h0108, 2'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h3020, 0, 0, 2'd0));
`else
      tbl.push_back(mk(1, 32'h3020, 32'h2421_0008, 16'h0108, 0, 0, 0,
                       0, 1, 32'h301C, 32'h2421_0007, 16'h0107, 2'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h301C, 0, 0, 2'd0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h301C, 0, 0, 2'd0));
`endif
      // drain without refill: bubble keeps 0x3008
      tbl.push_back(mk(1, 32'h3008, 32'h8C22_0008, 16'h0BEE, 0, 0, 0,
                       1, 1, 32'h3008, 32'h8C22_0008, 16'h0BEE, 2'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h3008, 0, 0, 2'd0));
      // flush with a concurrent input transfer that must be discarded
      tbl.push_back(mk(1, 32'h300C, 32'h0000_0020, 16'h0C0C, 0, 0, 0,
                       1, 1, 32'h300C, 32'h0000_0020, 16'h0C0C, 2'd1));
      tbl.push_back(mk(1, 32'h3014, 32'hAAAA_5555, 16'h1414, 1, 32'h3010, 1,
                       1, 0, 32'h3010, 0, 0, 2'd0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h3010, 0, 0, 2'd0));
      tbl.push_back(mk(1, 32'h3018, 32'h2421_0018, 16'h1818, 0, 0, 1,
                       1, 1, 32'h3018, 32'h2421_0018, 16'h1818, 2'd1));

      // ---- reset ----
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk_out("reset", 0, 32'h0000_3000, 0, 0, 2'd0);
      reset = 1'b0;
      #1;
      chk("reset.in_ready", 64'(in_ready), 64'd1);

      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

      // ---- asynchronous reset while full ----
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      reset = 1'b1;
      #1;
      chk_out("areset", 0, 32'h0000_3000, 0, 0, 2'd0);
      @(negedge clk);
      reset = 1'b0;
      apply(mk(1, 32'h3040, 32'h3C01_1234, 16'h4040, 0, 0, 1,
               1, 1, 32'h3040, 32'h3C01_1234, 16'h4040, 2'd1), "resume");
      apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h3040, 0, 0, 2'd0), "resume_drain");

`ifdef PIPE_STAGE_SKID_EN
      // ---- back-pressure into the skid entry, then in-order release ----
      apply(mk(1, 32'h3000, 32'h1111_0000, 16'h0A00, 0, 0, 0,
               1, 1, 32'h3000, 32'h1111_0000, 16'h0A00, 2'd1), "bp0");
      apply(mk(1, 32'h3004, 32'h1111_0004, 16'h0A04, 0, 0, 0,
               1, 1, 32'h3000, 32'h1111_0000, 16'h0A00, 2'd2), "bp1");
      chk("bp1.in_ready_full", 64'(in_ready), 64'd0);
      apply(mk(0, 0, 0, 0, 0, 0, 1,
               0, 1, 32'h3004, 32'h1111_0004, 16'h0A04, 2'd1), "bp2");
      chk("bp2.in_ready_back", 64'(in_ready), 64'd1);
      // ---- refill to two entries, then flush with in_valid high ----
      apply(mk(1, 32'h3008, 32'h1111_0008, 16'h0A08, 0, 0, 0,
               1, 1, 32'h3004, 32'h1111_0004, 16'h0A04, 2'd2), "fl0");
      apply(mk(1, 32'h300C, 32'h1111_000C, 16'h0A0C, 1, 32'h3010, 0,
               0, 0, 32'h3010, 0, 0, 2'd0), "fl1");
      apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h3010, 0, 0, 2'd0), "fl2");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core. It generalises the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block with a valid/ready handshake, flush with bubble-PC insertion and a configurable payload width. An optional two-entry skid buffer removes the combinational ready path. Every stage boundary instantiates it, with `DATA_W` sized to that boundary's payload.

## Interface
- `DATA_W`, 96, width of the opaque payload, e.g. rs/rt data and extended immediate; must be ≥ 1.
- `RESET_PC`, 32'h0000_3000, value of `out_pc` after reset.
- `clk  in  1  system clock; all state changes on its rising edge.`
- `reset  in  1  asynchronous, active-high reset.`
- `in_valid  in  1  upstream holds a valid instruction.`
- `in_ready  out  1  block can accept this cycle.`
- `in_pc  in  32  PC of incoming instruction.`
- `in_instr  in  32  incoming instruction word.`
- `in_data  in  DATA_W  incoming payload.`
- `flush  in  1  discard all held and incoming entries.`
- `flush_pc  in  32  PC carried by the bubble created on flush.`
- `out_valid  out  1  output entry valid.`
- `out_ready  in  1  downstream accepts this cycle.`
- `out_pc  out  32  PC of output entry, or bubble PC.`
- `out_instr  out  32  output instruction; 0 (nop) whenever `out_valid`=0.`
- `out_data  out  DATA_W  output payload; 0 whenever `out_valid`=0.`
- `occupancy  out  2  number of valid entries held: 0..1, or 0..2 with skid.`

## Operation
- Reset, asserted asynchronously: `out_valid`=0, `out_instr`=0, `out_data`=0, `out_pc`=`RESET_PC`, `occupancy`=0, skid entry cleared.
- An input transfer occurs when `in_valid` & `in_ready`. An output transfer occurs when `out_valid` & `out_ready`.
- Main register (M) drives the outputs. M loads on an input transfer when M is empty or is being drained in the same cycle.
- Flush has priority over everything. On the next edge all entries are invalidated, `out_pc`←`flush_pc`, `out_instr`/`out_data`←0 and `occupancy`←0. An input transfer in the same cycle is discarded, although `in_ready` may already have been high.
- When M is drained and no input transfer occurs, `out_valid`←0 and `out_instr`/`out_data`←0. `out_pc` keeps the drained entry's PC, so the bubble carries the last PC.
- The payload is opaque. No field is interpreted and there is no width conversion.

## Timing
- Latency is one cycle from input transfer to `out_valid` in both modes. Throughput is one instruction per cycle while `out_ready`=1.
- Without skid: `in_ready` = !`out_valid` | `out_ready`. This is combinational from `out_ready`.
- With skid: `in_ready` = !skid_valid and is registered, with no combinational path from `out_ready`.
  - M full, not drained, input transfer → entry goes to skid; `occupancy`=2; `in_ready`=0 next cycle.
  - M drained while skid is valid → M←skid next edge; `in_ready` returns to 1.
- Simultaneous drain and fill keeps occupancy unchanged. Occupancy never exceeds capacity, and an input transfer while full cannot occur by construction.
- Reset mid-transfer: the entry is lost and outputs take their reset values immediately, without waiting for a clock edge.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: two-entry (M + skid) buffer, registered `in_ready`, `occupancy` range 0..2.
- Not defined: single register, combinational `in_ready`, `occupancy` range 0..1 (bit 1 tied to 0). Skid logic is not synthesised.

## Test plan
- Reset, then release: `out_pc`=32'h0000_3000, `out_valid`=0, `out_instr`=0, `in_ready`=1 → first input transfer with pc 0x3000 / instr 0x3C011234 appears one cycle later with `out_valid`=1.
- Streaming with `out_ready`=1 for 8 cycles, pc 0x3000..0x301C: outputs follow one cycle delayed, no gaps, `occupancy` stays 1.
- Back-pressure, skid build only: hold `out_ready`=0 while sending 0x3000 then 0x3004 → `occupancy`=2, `in_ready`=0. Release `out_ready` → 0x3000 then 0x3004 emerge in order, no loss or duplication. Without skid: `in_ready`=0 after the first entry.
- Flush while `occupancy`=2 and `in_valid`=1, with `flush_pc`=0x3010 → next cycle `out_valid`=0, `out_instr`=0, `out_pc`=0x3010, `occupancy`=0. The concurrent input never appears.
- Assert `reset` asynchronously between edges while full → outputs reach reset values before the next edge. Traffic resumes normally after release.
- Drain without refill: after last entry 0x3008 is accepted downstream → `out_valid`=0, `out_instr`=0, `out_pc` stays 0x3008.
